// File: rtl/equiv_pkg.sv
// Shared types and helpers for the on-board equivalence checker.
package equiv_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle    = 2'd0,
    StSettle  = 2'd1,
    StCompare = 2'd2,
    StDone    = 2'd3
  } state_e;

  // All-ones value of the given width, right-aligned in 32 bits.
  function automatic logic [31:0] all_ones(input int unsigned width);
    return (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counter that spaces vector changes from output comparisons.
module settle_timer #(
  parameter int unsigned Settle = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (Settle > 1) ? $clog2(Settle) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(Settle - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LoadVal;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/equiv_checker.sv
// Sweeps every input vector through two models and counts output mismatches.
module equiv_checker
  import equiv_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned W_CNT  = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  vec,
  input  logic             f_dut,
  input  logic             f_ref,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             done_seen,
  output logic [W_CNT-1:0] fail_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_valid
);

  localparam logic [N_IN-1:0]  VecMax = N_IN'(all_ones(N_IN));
  localparam logic [W_CNT-1:0] CntMax = W_CNT'(all_ones(W_CNT));

  state_e           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [W_CNT-1:0] fail_q, fail_d;
  logic [N_IN-1:0]  ffv_q, ffv_d;
  logic             ffvalid_q, ffvalid_d;
  logic             pass_q, pass_d;
  logic             done_seen_q, done_seen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmr_load, tmr_en, tmr_expired;
  logic             mismatch;

  settle_timer #(
    .Settle (SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  assign mismatch = f_dut ^ f_ref;

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    fail_d      = fail_q;
    ffv_d       = ffv_q;
    ffvalid_d   = ffvalid_q;
    pass_d      = pass_q;
    done_seen_d = done_seen_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          vec_d     = '0;
          fail_d    = '0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          tmr_load  = 1'b1;
          state_d   = StSettle;
        end
      end
      StSettle: begin
        if (tmr_expired) begin
          state_d = StCompare;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StCompare: begin
        if (mismatch) begin
          if (fail_q != CntMax) begin
            fail_d = fail_q + W_CNT'(1);
          end
          if (!ffvalid_q) begin
            ffv_d     = vec_q;
            ffvalid_d = 1'b1;
          end
        end
        if (vec_q == VecMax) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          vec_d    = vec_q + N_IN'(1);
          tmr_load = 1'b1;
          state_d  = StSettle;
        end
      end
      StDone: begin
        // fail_q already includes the last compare's update here.
        pass_d      = (fail_q == '0);
        done_seen_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      vec_q       <= '0;
      fail_q      <= '0;
      ffv_q       <= '0;
      ffvalid_q   <= 1'b0;
      pass_q      <= 1'b0;
      done_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      fail_q      <= fail_d;
      ffv_q       <= ffv_d;
      ffvalid_q   <= ffvalid_d;
      pass_q      <= pass_d;
      done_seen_q <= done_seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign vec              = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign done_seen        = done_seen_q;
  assign fail_count       = fail_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_equiv_checker.sv
// Directed bench: default checker against several developer models, plus a
// 3-input instance with a 2-bit counter to exercise saturation.
module tb_equiv_checker;

  logic       clk = 1'b0;
  logic       rst_n, start, start_s;
  logic [1:0] vec, ffv;
  logic [2:0] fail_count;
  logic       f_dut, f_ref, busy, done, pass, done_seen, ffvalid;

  logic [2:0] vec_s, ffv_s;
  logic [1:0] fc_s;
  logic       f_dut_s, f_ref_s, busy_s, done_s, pass_s, done_seen_s, ffvalid_s;

  int tests = 0;
  int fails = 0;
  int mode  = 0;

  typedef struct {
    int fc;
    int ffv;
    bit ffvalid;
    bit pass;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // 0: correct XOR, 1: OR, other: constant 1.
  function automatic logic dut_model(input int m, input logic [1:0] v);
    case (m)
      0:       return v[0] ^ v[1];
      1:       return v[0] | v[1];
      default: return 1'b1;
    endcase
  endfunction

  always_comb f_dut = dut_model(mode, vec);
  assign f_ref   = vec[0] ^ vec[1];
  assign f_dut_s = 1'b0;
  assign f_ref_s = 1'b1;

  equiv_checker u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .vec              (vec),
    .f_dut            (f_dut),
    .f_ref            (f_ref),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .done_seen        (done_seen),
    .fail_count       (fail_count),
    .first_fail_vec   (ffv),
    .first_fail_valid (ffvalid)
  );

  equiv_checker #(
    .N_IN   (3),
    .SETTLE (1),
    .W_CNT  (2)
  ) u_sat (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start_s),
    .vec              (vec_s),
    .f_dut            (f_dut_s),
    .f_ref            (f_ref_s),
    .busy             (busy_s),
    .done             (done_s),
    .pass             (pass_s),
    .done_seen        (done_seen_s),
    .fail_count       (fc_s),
    .first_fail_vec   (ffv_s),
    .first_fail_valid (ffvalid_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result for one sweep of the default instance.
  function automatic exp_t predict(input int m);
    exp_t e;
    logic [1:0] vv;
    e.fc = 0; e.ffv = 0; e.ffvalid = 1'b0;
    for (int v = 0; v < 4; v++) begin
      vv = 2'(v);
      if (dut_model(m, vv) != (vv[0] ^ vv[1])) begin
        if (e.fc < 7) e.fc++;
        if (!e.ffvalid) begin
          e.ffv = v;
          e.ffvalid = 1'b1;
        end
      end
    end
    e.pass = (e.fc == 0);
    return e;
  endfunction

  // hold: keep start high for two back-to-back sweeps.
  // pokes: pulse start at t0+3 and t0+8, which must be ignored.
  task automatic sweep(input int m, input bit hold, input bit pokes);
    exp_t e, cur;
    int   kk, ndone, limit;
    bit   exp_done;
    mode = m;
    e = predict(m);
    cur = e;
    sb.push_back(e);
    if (hold) sb.push_back(e);
    ndone = 0;
    limit = hold ? 20 : 10;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = hold;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (pokes) start = (k == 3 || k == 8);
      kk = (k <= 10) ? k : k - 10;
      exp_done = (kk == 9);
      check("done", done, exp_done);
      check("busy", busy, (kk >= 1 && kk <= 8));
      check("vec", vec, (kk <= 8) ? (kk - 1) / 2 : 3);
      if (done === 1'b1) begin
        ndone++;
        check("sb_size", sb.size(), hold ? 3 - ndone : 1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          check("fail_count", fail_count, cur.fc);
          check("ffvalid", ffvalid, cur.ffvalid);
          if (cur.ffvalid) check("ffv", ffv, cur.ffv);
        end
      end
      if (kk == 10) begin
        check("pass", pass, cur.pass);
        check("done_seen", done_seen, 1);
      end
      if (hold && k == 19) start = 1'b0;
    end
    check("n_done", ndone, hold ? 2 : 1);
  endtask

  initial begin
    exp_t es;
    rst_n   = 1'b0;
    start   = 1'b0;
    start_s = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vec", vec, 0);
    check("rst_fc", fail_count, 0);
    check("rst_pass", pass, 0);
    check("rst_done_seen", done_seen, 0);
    check("rst_ffvalid", ffvalid, 0);
    check("rst_ffv", ffv, 0);
    check("rst_sat_fc", fc_s, 0);
    rst_n = 1'b1;

    sweep(0, 1'b0, 1'b0);
    sweep(1, 1'b0, 1'b0);
    sweep(2, 1'b0, 1'b0);
    sweep(0, 1'b0, 1'b1);
    sweep(0, 1'b1, 1'b0);

    // Saturating instance: eight mismatches into a 2-bit counter.
    es.fc = 0; es.ffv = 0; es.ffvalid = 1'b0;
    for (int v = 0; v < 8; v++) begin
      if (f_dut_s != f_ref_s) begin
        if (es.fc < 3) es.fc++;
        if (!es.ffvalid) begin
          es.ffv = v;
          es.ffvalid = 1'b1;
        end
      end
    end
    es.pass = (es.fc == 0);
    sb.push_back(es);
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      check("sat_done", done_s, (k == 17));
      check("sat_busy", busy_s, (k <= 16));
      if (k <= 16) check("sat_vec", vec_s, (k - 1) / 2);
      if (done_s === 1'b1) begin
        check("sat_sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
          es = sb.pop_front();
          check("sat_fc", fc_s, es.fc);
          check("sat_ffvalid", ffvalid_s, es.ffvalid);
          check("sat_ffv", ffv_s, es.ffv);
        end
      end
      if (k == 18) begin
        check("sat_pass", pass_s, es.pass);
        check("sat_done_seen", done_seen_s, 1);
      end
    end

    // Reset in the middle of a failing sweep.
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vec", vec, 0);
    check("mid_rst_fc", fail_count, 0);
    check("mid_rst_ffvalid", ffvalid, 0);
    check("mid_rst_done_seen", done_seen, 0);
    check("mid_rst_pass", pass, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    sweep(0, 1'b0, 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
